ray_dispatcher: RTL
===================

# ray_dispatcher

Issues rays into `ray_intersector` and drives its scene-buffer interface. Owns the object store, which the scene loader writes. On each accepted ray request it pulses `ray_valid`, holds the ray stable and streams every object on `obj`, one per cycle. It then waits for the intersector's `hit_valid` before accepting the next ray. It sits between the per-pixel tracer FSM and `ray_intersector`.

## Interface
- `MAX_OBJS`, default `MAX_NUM_OBJS`: object store depth.
- `TIMEOUT_SLACK`, default `DISPATCH_TIMEOUT_SLACK` (8): extra wait cycles before the watchdog fires.
- `clk`  in  1  clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `wr_en`  in  1  scene write strobe
- `wr_addr`  in  $clog2(MAX_OBJS)  object slot to write
- `wr_obj`  in  $bits(object)  object data to write
- `num_objs_we`  in  1  strobe that loads `num_objs_in`
- `num_objs_in`  in  $clog2(MAX_OBJS)  new object count
- `req_valid`  in  1  ray request valid
- `req_ready`  out  1  dispatcher can accept a ray
- `req_origin`  in  fp_vec3  requested ray origin
- `req_dir`  in  fp_vec3  requested ray direction
- `ray_origin`  out  fp_vec3  ray origin to intersector
- `ray_dir`  out  fp_vec3  ray direction to intersector
- `ray_valid`  out  1  single-cycle trigger to intersector
- `num_objs`  out  $clog2(MAX_OBJS)  object count to intersector
- `obj`  out  object  streamed object
- `hit_valid`  in  1  intersector done pulse
- `scene_locked`  out  1  high when not in IDLE
- `timeout`  out  1  single-cycle pulse when the watchdog fires

## Operation
- States are IDLE, STREAM and WAIT_HIT.
- **IDLE**
  - `req_ready` = (`num_objs` != 0).
  - On `req_valid && req_ready`: latch `req_origin`/`req_dir` into `ray_origin`/`ray_dir`, clear `idx`, go to STREAM.
- **STREAM**
  - Cycle k (k = 0..num_objs-1) drives `obj` = store[k], registered.
  - `ray_valid` = 1 in cycle 0 only.
  - After the cycle with k = num_objs-1, go to WAIT_HIT and clear the watchdog.
- **WAIT_HIT**
  - `hit_valid` returns the FSM to IDLE.
  - Otherwise the watchdog increments. At num_objs + SPHERE_INTX_DELAY + TIMEOUT_SLACK it pulses `timeout` and returns to IDLE.
- `ray_origin`/`ray_dir` hold from the accept edge until the FSM returns to IDLE.
- Outside STREAM, `obj` = 0.
- `wr_en` and `num_objs_we` take effect only in IDLE, including the accept cycle. A write to any slot on the accept edge is visible to that ray. Writes while `scene_locked` are dropped.
- `hit_valid` in IDLE or STREAM is stale and ignored.
- `num_objs_in` > MAX_OBJS saturates to MAX_OBJS. `idx` never wraps.

## Timing
- Reset (asynchronous, any state, including mid-stream) immediately forces:
  - state IDLE
  - `ray_valid`=0, `obj`=0, `ray_origin`=0, `ray_dir`=0
  - `num_objs`=0, so `req_ready`=0
  - `scene_locked`=0, `timeout`=0
  - store cleared to 0
- Accept at edge T gives:
  - `ray_valid`=1 and `obj`=store[0] during cycle T+1
  - `obj`=store[n-1] during cycle T+n
  - WAIT_HIT from cycle T+n+1
- `hit_valid` from the intersector arrives about n+SPHERE_INTX_DELAY+1 cycles after `ray_valid`.
- Minimum issue interval is n+2+latency cycles. There is no overlap between rays.
- `req_ready` is combinational from state and `num_objs` only, never from `req_valid`.

## Structure
- `object`, `material`, `fp_vec3`, `MAX_NUM_OBJS` and `SPHERE_INTX_DELAY` live in the shared package. Add `DISPATCH_TIMEOUT_SLACK` (8) there.
- Sub-module `scene_mem`: MAX_OBJS×object register array with async clear, one write port and one registered read port. The FSM and watchdog stay in `ray_dispatcher`.

## Test plan
- **Basic ray:** load 3 objects, set num_objs=3, request one ray.
  - `ray_valid` pulses once at T+1.
  - `obj` = slots 0, 1, 2 on T+1..T+3, then 0.
  - `ray_origin` is stable until `hit_valid`.
- **Empty scene:** set num_objs=0, hold `req_valid`. `req_ready` stays 0 and `ray_valid` never fires.
- **Locked writes and stale done:**
  - Write slot 1 during STREAM: write is dropped, and the next ray sees the old slot 1.
  - Pulse `hit_valid` during STREAM: it is ignored.
- **Accept-edge write:** write slot 0 = X on the same edge as accept. `obj` at T+1 equals X.
- **Watchdog:** with num_objs=4, never return `hit_valid`.
  - `timeout` pulses at 4+SPHERE_INTX_DELAY+8 cycles into WAIT_HIT.
  - IDLE follows and `req_ready`=1.
- **Reset mid-stream:** drop `rst_n` at stream cycle 2.
  - `ray_valid`, `obj` and `num_objs` go to 0 immediately.
  - After release, `req_ready`=0 until `num_objs` is reloaded.

Source files
------------

// File: rtl/ray_dispatcher_pkg.sv
// Shared ray-tracer types and sizing constants used by the dispatcher and
// the intersector.
package ray_dispatcher_pkg;

  typedef logic signed [15:0] fp_t;

  typedef struct packed {
    fp_t x;
    fp_t y;
    fp_t z;
  } fp_vec3;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] reflect;
  } material;

  typedef struct packed {
    fp_vec3  center;
    fp_t     radius;
    material mat;
  } object;

  localparam int MAX_NUM_OBJS           = 6;
  localparam int SPHERE_INTX_DELAY      = 4;
  localparam int DISPATCH_TIMEOUT_SLACK = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_STREAM   = 2'd1,
    ST_WAIT_HIT = 2'd2
  } disp_state_e;

endpackage

// File: rtl/ray_dispatcher_scene_mem.sv
// Object store: register array with async clear, one write port and one
// registered read port that forwards write data landing on the same edge.
module scene_mem
  import ray_dispatcher_pkg::*;
#(
  parameter int DEPTH = MAX_NUM_OBJS,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  object         wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output object         rdata
);

  object mem_r [DEPTH];
  object rd_s;
  object rdata_r;

  // Storage array; writes to slots beyond DEPTH are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (we && (32'(waddr) < 32'(DEPTH))) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read mux with same-edge write bypass.
  always_comb begin
    rd_s = '0;
    if (we && (waddr == raddr)) begin
      rd_s = wdata;
    end else if (32'(raddr) < 32'(DEPTH)) begin
      rd_s = mem_r[raddr];
    end else begin
      rd_s = '0;
    end
  end

  // Read register; returns zero whenever no read is requested.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= '0;
    end else if (re) begin
      rdata_r <= rd_s;
    end else begin
      rdata_r <= '0;
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/ray_dispatcher.sv
// Ray dispatcher: accepts one ray at a time, streams the scene to the
// intersector and waits for its done pulse, with a watchdog fallback.
module ray_dispatcher
  import ray_dispatcher_pkg::*;
#(
  parameter int MAX_OBJS      = MAX_NUM_OBJS,
  parameter int TIMEOUT_SLACK = DISPATCH_TIMEOUT_SLACK
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en,
  input  logic [$clog2(MAX_OBJS)-1:0] wr_addr,
  input  object                       wr_obj,
  input  logic                        num_objs_we,
  input  logic [$clog2(MAX_OBJS)-1:0] num_objs_in,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  fp_vec3                      req_origin,
  input  fp_vec3                      req_dir,
  output fp_vec3                      ray_origin,
  output fp_vec3                      ray_dir,
  output logic                        ray_valid,
  output logic [$clog2(MAX_OBJS)-1:0] num_objs,
  output object                       obj,
  input  logic                        hit_valid,
  output logic                        scene_locked,
  output logic                        timeout
);

  localparam int AW   = $clog2(MAX_OBJS);
  localparam int WD_W = 16;

  disp_state_e     state_r;
  disp_state_e     state_s;
  logic [AW-1:0]   idx_r;
  logic [AW-1:0]   num_objs_r;
  logic [AW-1:0]   num_sat_s;
  logic [AW-1:0]   rd_addr_s;
  logic [WD_W-1:0] wd_r;
  logic [WD_W-1:0] limit_s;
  logic            accept_s;
  logic            rd_en_s;
  logic            stream_last_s;
  logic            wd_fire_s;
  logic            idle_s;
  logic            wr_allow_s;
  logic            ray_valid_r;
  logic            timeout_r;
  fp_vec3          ray_origin_r;
  fp_vec3          ray_dir_r;

  assign idle_s     = (state_r == ST_IDLE);
  assign req_ready  = idle_s && (num_objs_r != '0);
  assign wr_allow_s = idle_s && wr_en;
  assign limit_s    = WD_W'(num_objs_r) + WD_W'(SPHERE_INTX_DELAY + TIMEOUT_SLACK);
  assign num_sat_s  = (32'(num_objs_in) > 32'(MAX_OBJS)) ? AW'(MAX_OBJS) : num_objs_in;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state, read-port control and watchdog fire decision.
  always_comb begin
    state_s       = state_r;
    accept_s      = 1'b0;
    rd_en_s       = 1'b0;
    rd_addr_s     = '0;
    stream_last_s = 1'b0;
    wd_fire_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          accept_s = 1'b1;
          rd_en_s  = 1'b1;
          state_s  = ST_STREAM;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_STREAM: begin
        // Compared wide so idx can never step past the last slot.
        if ((32'(idx_r) + 32'd1) >= 32'(num_objs_r)) begin
          stream_last_s = 1'b1;
          state_s       = ST_WAIT_HIT;
        end else begin
          rd_en_s   = 1'b1;
          rd_addr_s = idx_r + AW'(1);
        end
      end
      ST_WAIT_HIT: begin
        if (hit_valid) begin
          state_s = ST_IDLE;
        end else if ((wd_r + WD_W'(1)) == limit_s) begin
          wd_fire_s = 1'b1;
          state_s   = ST_IDLE;
        end else begin
          state_s = ST_WAIT_HIT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Ray latch, stream index, watchdog and output pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ray_origin_r <= '0;
      ray_dir_r    <= '0;
      idx_r        <= '0;
      wd_r         <= '0;
      ray_valid_r  <= 1'b0;
      timeout_r    <= 1'b0;
    end else begin
      ray_valid_r <= accept_s;
      timeout_r   <= wd_fire_s;
      if (accept_s) begin
        ray_origin_r <= req_origin;
        ray_dir_r    <= req_dir;
        idx_r        <= '0;
      end else if ((state_r == ST_STREAM) && !stream_last_s) begin
        idx_r <= idx_r + AW'(1);
      end else begin
        idx_r <= idx_r;
      end
      if (stream_last_s) begin
        wd_r <= '0;
      end else if ((state_r == ST_WAIT_HIT) && !hit_valid && !wd_fire_s) begin
        wd_r <= wd_r + WD_W'(1);
      end else begin
        wd_r <= wd_r;
      end
    end
  end

  // Object count, writable only while the scene is unlocked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_objs_r <= '0;
    end else if (idle_s && num_objs_we) begin
      num_objs_r <= num_sat_s;
    end else begin
      num_objs_r <= num_objs_r;
    end
  end

  scene_mem #(
    .DEPTH (MAX_OBJS),
    .AW    (AW)
  ) u_scene_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_allow_s),
    .waddr (wr_addr),
    .wdata (wr_obj),
    .re    (rd_en_s),
    .raddr (rd_addr_s),
    .rdata (obj)
  );

  assign ray_origin   = ray_origin_r;
  assign ray_dir      = ray_dir_r;
  assign ray_valid    = ray_valid_r;
  assign num_objs     = num_objs_r;
  assign scene_locked = !idle_s;
  assign timeout      = timeout_r;

endmodule
